fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and
// stall/flush event counters, sequenced by a BOOT/RUN state machine.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] redirect_pc;
  logic [31:0] seq_pc;

  // Redirects are forced to word alignment; sequential PC wraps naturally.
  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign seq_pc      = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (PCSrc) begin
          pc_d = redirect_pc;
        end else if (PCwrite) begin
          pc_d = seq_pc;
        end

        // A taken redirect squashes the fetched word even when IF/ID is held.
        if (PCSrc) begin
          ifid_pc_d    = 32'd0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (IF_IDwrite) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          ifid_valid_d = 1'b1;
        end

        if (!PCwrite && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (PCSrc && (flush_cnt_q != 16'hFFFF)) begin
          flush_cnt_d = flush_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
